// File: rtl/ssi_display_arbiter.sv
// Picks which 14-bit value drives the 4-digit display: live BPM, the tempo being edited (blinking),
// or a transient message that is held for a fixed time. Priority is EDIT > MSG > BPM.
module ssi_display_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_bpm_count,
    input  logic        i_edit_active,
    input  logic [13:0] i_edit_value,
    input  logic        i_msg_valid,
    input  logic [13:0] i_msg_value,
    output logic        o_msg_ready,
    output logic [13:0] o_number,
    output logic        o_blank,
    output logic [1:0]  o_source,
    output logic        o_load
);

    localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HOLD_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);
    localparam logic [13:0]       MaxNum    = 14'd9999;

    typedef enum logic [1:0] {
        S_BPM  = 2'd0,
        S_EDIT = 2'd1,
        S_MSG  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic [13:0]       msg_q, msg_d;
    logic [13:0]       number_q, number_d;
    logic              blank_q, blank_d;
    logic              load_q, load_d;
    logic              msg_ready;
    logic              msg_accept;
    logic [13:0]       sel_value;

    // Ready is gated by reset so nothing can be handed over while the block is held in reset.
    assign msg_ready  = i_reset && !i_edit_active && (state_q != S_EDIT);
    assign msg_accept = i_msg_valid && msg_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        msg_d   = msg_q;

        if (i_edit_active) begin
            // Editing pre-empts everything and throws away any message being held.
            state_d = S_EDIT;
            hold_d  = '0;
            msg_d   = '0;
        end else if (state_q == S_EDIT) begin
            state_d = S_BPM;
        end else if (msg_accept) begin
            state_d = S_MSG;
            hold_d  = HoldLoad;
            msg_d   = i_msg_value;
        end else if (state_q == S_MSG) begin
            if (hold_q == '0) begin
                state_d = S_BPM;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    always_comb begin
        blink_d = '0;
        blank_d = 1'b0;
        // Counter only runs while staying in edit, so entry always starts from a visible phase.
        if ((state_q == S_EDIT) && (state_d == S_EDIT)) begin
            if (blink_q == BlinkLast) begin
                blink_d = '0;
                blank_d = ~blank_q;
            end else begin
                blink_d = blink_q + 1'b1;
                blank_d = blank_q;
            end
        end
    end

    // Selecting on the next state keeps o_number aligned with o_source.
    always_comb begin
        unique case (state_d)
            S_EDIT:  sel_value = i_edit_value;
            S_MSG:   sel_value = msg_d;
            default: sel_value = i_bpm_count;
        endcase
        number_d = (sel_value > MaxNum) ? MaxNum : sel_value;
        load_d   = (number_d != number_q) || (blank_d != blank_q);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_BPM;
            hold_q   <= '0;
            blink_q  <= '0;
            msg_q    <= '0;
            number_q <= '0;
            blank_q  <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            blink_q  <= blink_d;
            msg_q    <= msg_d;
            number_q <= number_d;
            blank_q  <= blank_d;
            load_q   <= load_d;
        end
    end

    assign o_msg_ready = msg_ready;
    assign o_number    = number_q;
    assign o_blank     = blank_q;
    assign o_source    = state_q;
    assign o_load      = load_q;

endmodule

// File: tb/tb_ssi_display_arbiter.sv
// Directed bench for ssi_display_arbiter with HOLD_CYCLES=8, BLINK_CYCLES=4.
module tb_ssi_display_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic [13:0] i_bpm_count;
    logic        i_edit_active;
    logic [13:0] i_edit_value;
    logic        i_msg_valid;
    logic [13:0] i_msg_value;
    logic        o_msg_ready;
    logic [13:0] o_number;
    logic        o_blank;
    logic [1:0]  o_source;
    logic        o_load;

    int total;
    int bad;

    ssi_display_arbiter #(
        .HOLD_CYCLES (8),
        .BLINK_CYCLES(4)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_bpm_count  (i_bpm_count),
        .i_edit_active(i_edit_active),
        .i_edit_value (i_edit_value),
        .i_msg_valid  (i_msg_valid),
        .i_msg_value  (i_msg_value),
        .o_msg_ready  (o_msg_ready),
        .o_number     (o_number),
        .o_blank      (o_blank),
        .o_source     (o_source),
        .o_load       (o_load)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_bpm_count = 14'd120;
        i_edit_active = 1'b0;
        i_edit_value = 14'd0;
        i_msg_valid = 1'b0;
        i_msg_value = 14'd0;
        step();
        step();
        total++;
        if (o_number !== 14'd0 || o_blank !== 1'b0 || o_source !== 2'd0 || o_load !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got num=%0d blank=%b src=%0d load=%b, want 0/0/0/0",
                     o_number, o_blank, o_source, o_load);
        end
        total++;
        if (o_msg_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0", o_msg_ready);
        end
        i_reset = 1'b1;
        step();
        total++;
        if (o_number !== 14'd120 || o_load !== 1'b1 || o_source !== 2'd0) begin
            bad++;
            $display("FAIL release_first_edge: got num=%0d load=%b src=%0d, want 120/1/0",
                     o_number, o_load, o_source);
        end
        step();
        total++;
        if (o_number !== 14'd120 || o_load !== 1'b0) begin
            bad++;
            $display("FAIL release_steady: got num=%0d load=%b, want 120/0", o_number, o_load);
        end
    endtask

    task automatic test_msg();
        i_msg_valid = 1'b1;
        i_msg_value = 14'd4;
        #1;
        total++;
        if (o_msg_ready !== 1'b1) begin
            bad++;
            $display("FAIL msg_ready_idle: got %b want 1", o_msg_ready);
        end
        step();
        i_msg_valid = 1'b0;
        i_bpm_count = 14'd121;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (o_source !== 2'd2 || o_number !== 14'd4 || o_load !== (k == 0)) begin
                bad++;
                $display("FAIL msg_hold[%0d]: got src=%0d num=%0d load=%b, want 2/4/%b",
                         k, o_source, o_number, o_load, (k == 0));
            end
            step();
        end
        total++;
        if (o_source !== 2'd0 || o_number !== 14'd121 || o_load !== 1'b1) begin
            bad++;
            $display("FAIL msg_expire: got src=%0d num=%0d load=%b, want 0/121/1",
                     o_source, o_number, o_load);
        end
    endtask

    task automatic test_retrigger();
        i_msg_valid = 1'b1;
        i_msg_value = 14'd4;
        step();
        i_msg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (o_source !== 2'd2 || o_number !== 14'd4) begin
                bad++;
                $display("FAIL retrig_first[%0d]: got src=%0d num=%0d, want 2/4",
                         k, o_source, o_number);
            end
            if (k == 4) begin
                i_msg_valid = 1'b1;
                i_msg_value = 14'd7;
            end
            step();
        end
        i_msg_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (o_source !== 2'd2 || o_number !== 14'd7) begin
                bad++;
                $display("FAIL retrig_second[%0d]: got src=%0d num=%0d, want 2/7",
                         k, o_source, o_number);
            end
            step();
        end
        total++;
        if (o_source !== 2'd0 || o_number !== 14'd121) begin
            bad++;
            $display("FAIL retrig_expire: got src=%0d num=%0d, want 0/121", o_source, o_number);
        end
    endtask

    task automatic test_edit();
        i_edit_active = 1'b1;
        i_edit_value = 14'd135;
        #1;
        total++;
        if (o_msg_ready !== 1'b0) begin
            bad++;
            $display("FAIL edit_ready: got %b want 0", o_msg_ready);
        end
        step();
        for (int k = 0; k < 13; k++) begin
            total++;
            if (o_source !== 2'd1 || o_number !== 14'd135 || o_blank !== (((k / 4) % 2) == 1)
                || o_load !== ((k % 4) == 0)) begin
                bad++;
                $display("FAIL edit_blink[%0d]: got src=%0d num=%0d blank=%b load=%b, want 1/135/%b/%b",
                         k, o_source, o_number, o_blank, o_load, (((k / 4) % 2) == 1),
                         ((k % 4) == 0));
            end
            if (k < 12) step();
        end
        i_edit_active = 1'b0;
        #1;
        total++;
        if (o_msg_ready !== 1'b0) begin
            bad++;
            $display("FAIL edit_exit_ready: got %b want 0", o_msg_ready);
        end
        step();
        total++;
        if (o_source !== 2'd0 || o_blank !== 1'b0 || o_number !== 14'd121 || o_load !== 1'b1) begin
            bad++;
            $display("FAIL edit_exit: got src=%0d blank=%b num=%0d load=%b, want 0/0/121/1",
                     o_source, o_blank, o_number, o_load);
        end
    endtask

    task automatic test_collision();
        i_edit_active = 1'b1;
        i_msg_valid = 1'b1;
        i_msg_value = 14'd9;
        #1;
        total++;
        if (o_msg_ready !== 1'b0) begin
            bad++;
            $display("FAIL collide_ready: got %b want 0", o_msg_ready);
        end
        step();
        i_msg_valid = 1'b0;
        total++;
        if (o_source !== 2'd1 || o_number !== 14'd135) begin
            bad++;
            $display("FAIL collide_edit: got src=%0d num=%0d, want 1/135", o_source, o_number);
        end
        step();
        i_edit_active = 1'b0;
        step();
        total++;
        if (o_source !== 2'd0 || o_number !== 14'd121) begin
            bad++;
            $display("FAIL collide_after: got src=%0d num=%0d, want 0/121", o_source, o_number);
        end
        step();
        total++;
        if (o_source !== 2'd0 || o_number !== 14'd121 || o_msg_ready !== 1'b1) begin
            bad++;
            $display("FAIL collide_no_resume: got src=%0d num=%0d rdy=%b, want 0/121/1",
                     o_source, o_number, o_msg_ready);
        end
    endtask

    task automatic test_saturate();
        logic [13:0] vin  [4];
        logic [13:0] vexp [4];
        logic        lexp [4];
        vin[0] = 14'd12000; vexp[0] = 14'd9999; lexp[0] = 1'b1;
        vin[1] = 14'd10000; vexp[1] = 14'd9999; lexp[1] = 1'b0;
        vin[2] = 14'd9999;  vexp[2] = 14'd9999; lexp[2] = 1'b0;
        vin[3] = 14'd42;    vexp[3] = 14'd42;   lexp[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_bpm_count = vin[i];
            step();
            total++;
            if (o_number !== vexp[i] || o_load !== lexp[i]) begin
                bad++;
                $display("FAIL saturate[%0d]: in=%0d got num=%0d load=%b, want %0d/%b",
                         i, vin[i], o_number, o_load, vexp[i], lexp[i]);
            end
        end
        i_bpm_count = 14'd12000;
        step();
    endtask

    task automatic test_reset_mid_msg();
        i_msg_valid = 1'b1;
        i_msg_value = 14'd5;
        step();
        i_msg_valid = 1'b0;
        step();
        total++;
        if (o_source !== 2'd2 || o_number !== 14'd5) begin
            bad++;
            $display("FAIL midrst_pre: got src=%0d num=%0d, want 2/5", o_source, o_number);
        end
        i_reset = 1'b0;
        #1;
        total++;
        if (o_number !== 14'd0 || o_blank !== 1'b0 || o_source !== 2'd0 || o_load !== 1'b0
            || o_msg_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_abort: got num=%0d blank=%b src=%0d load=%b rdy=%b, want all 0",
                     o_number, o_blank, o_source, o_load, o_msg_ready);
        end
        step();
        i_bpm_count = 14'd200;
        i_reset = 1'b1;
        step();
        total++;
        if (o_source !== 2'd0 || o_number !== 14'd200 || o_load !== 1'b1) begin
            bad++;
            $display("FAIL midrst_release: got src=%0d num=%0d load=%b, want 0/200/1",
                     o_source, o_number, o_load);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            total++;
            if (o_source !== 2'd0 || o_number !== 14'd200) begin
                bad++;
                $display("FAIL midrst_no_resume[%0d]: got src=%0d num=%0d, want 0/200",
                         k, o_source, o_number);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_msg();
        test_retrigger();
        test_edit();
        test_collision();
        test_saturate();
        test_reset_mid_msg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
